// File: rtl/micro_seq_pkg.sv
// Shared constants, types and table helpers for the micro-step sequencer.
// Each opcode maps to one or two (alu, ctrl) flag words replayed on consecutive cycles.
package micro_seq_pkg;

    localparam logic [7:0] ALU_ADD = 8'h00;
    localparam logic [7:0] ALU_SUB = 8'hC0;
    localparam logic [7:0] ALU_XOR = 8'h20;
    localparam logic [7:0] ALU_NOR = 8'h2C;
    localparam logic [7:0] ALU_AND = 8'h7C;
    localparam logic [7:0] ALU_ROT = 8'h02;

    localparam logic [7:0] CTRL_JLR    = 8'h10;
    localparam logic [7:0] CTRL_JLI    = 8'h20;
    localparam logic [7:0] CTRL_LINK   = 8'h08;
    localparam logic [7:0] CTRL_BRANCH = 8'hA0;
    localparam logic [7:0] CTRL_ADI    = 8'h40;
    localparam logic [7:0] CTRL_STB    = 8'h04;
    localparam logic [7:0] CTRL_LDB    = 8'h02;
    localparam logic [7:0] CTRL_LDI    = 8'h01;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_NOR = 4'h3,
        OP_AND = 4'h4, OP_ROT = 4'h5, OP_JLR = 4'h7, OP_JLI = 4'h8,
        OP_BXX = 4'h9, OP_ADI = 4'hC, OP_STB = 4'hD, OP_LDB = 4'hE,
        OP_LDI = 4'hF
    } op_e;

    typedef enum logic {S_IDLE, S_EXEC} state_e;

    typedef struct packed {
        logic [7:0] alu;
        logic [7:0] ctrl;
    } step_t;

    function automatic logic is_legal(input logic [3:0] opc);
        case (opc)
            4'h6, 4'hA, 4'hB: return 1'b0;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic int unsigned step_count(input logic [3:0] opc);
        case (opc)
            OP_JLR, OP_JLI, OP_LDB: return 2;
            default:                return 1;
        endcase
    endfunction

    function automatic step_t micro_lookup(input logic [3:0] opc, input int unsigned stp);
        step_t w;
        w = '0;
        case (opc)
            OP_ADD: w.alu  = ALU_ADD;
            OP_SUB: w.alu  = ALU_SUB;
            OP_XOR: w.alu  = ALU_XOR;
            OP_NOR: w.alu  = ALU_NOR;
            OP_AND: w.alu  = ALU_AND;
            OP_ROT: w.alu  = ALU_ROT;
            OP_JLR: w.ctrl = (stp == 0) ? CTRL_JLR : CTRL_LINK;
            OP_JLI: w.ctrl = (stp == 0) ? CTRL_JLI : CTRL_LINK;
            OP_BXX: w.ctrl = CTRL_BRANCH;
            OP_ADI: w.ctrl = CTRL_ADI;
            OP_STB: w.ctrl = CTRL_STB;
            OP_LDB: w.ctrl = (stp == 0) ? 8'h00 : CTRL_LDB;
            OP_LDI: w.ctrl = CTRL_LDI;
            default: w = '0;
        endcase
        if (stp >= step_count(opc)) w = '0;
        return w;
    endfunction

endpackage

// File: rtl/micro_seq_if.sv
// Opcode handshake plus per-step flag outputs between fetch, sequencer and datapath.
interface micro_seq_if #(
    parameter int OPCODE_W = 4,
    parameter int ALU_W    = 8,
    parameter int CTRL_W   = 8,
    parameter int STEP_W   = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic                stall;
    logic                out_valid;
    logic [ALU_W-1:0]    alu_flags;
    logic [CTRL_W-1:0]   ctrl_flags;
    logic [STEP_W-1:0]   step;
    logic                last;
    logic                illegal;

    modport master (
        output in_valid, opcode, stall,
        input  in_ready, out_valid, alu_flags, ctrl_flags, step, last, illegal
    );

    modport slave (
        input  in_valid, opcode, stall,
        output in_ready, out_valid, alu_flags, ctrl_flags, step, last, illegal
    );
endinterface

// File: rtl/micro_rom.sv
// Combinational micro-step table: (opcode, step) -> flag words, step count, legality.
module micro_rom
    import micro_seq_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALU_W     = 8,
    parameter int CTRL_W    = 8,
    parameter int MAX_STEPS = 4,
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [STEP_W-1:0]   step_i,
    output logic [ALU_W-1:0]    alu_o,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic [STEP_W:0]     count_o,
    output logic                legal_o
);
    logic [3:0]  opc4;
    logic        in_table;
    int unsigned cnt;
    step_t       word;

    always_comb begin
        opc4     = 4'(opcode_i);
        in_table = (32'(opcode_i) < 32'd16);
        legal_o  = in_table && is_legal(opc4);
        cnt      = legal_o ? step_count(opc4) : 1;
        // Counts longer than the step counter can address are cut at elaboration size.
        if (cnt > 32'(MAX_STEPS)) cnt = 32'(MAX_STEPS);
        word     = legal_o ? micro_lookup(opc4, 32'(step_i)) : '0;
        count_o  = (STEP_W+1)'(cnt);
        alu_o    = ALU_W'(word.alu);
        ctrl_o   = CTRL_W'(word.ctrl);
    end
endmodule

// File: rtl/micro_sequencer.sv
// Registered micro-step sequencer: accepts an opcode and replays its table steps,
// holding under datapath stall and chaining the next opcode without a bubble.
//   state  | meaning
//   S_IDLE | no live step, outputs zero, ready for an opcode
//   S_EXEC | a step is on the outputs; advances when not stalled
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALU_W     = 8,
    parameter int CTRL_W    = 8,
    parameter int MAX_STEPS = 4,
    parameter int STEP_W    = $clog2(MAX_STEPS)
) (
    input logic        clk,
    input logic        rst,
    micro_seq_if.slave bus
);
    localparam logic [STEP_W-1:0] STEP_ONE = 1;
    localparam logic [STEP_W:0]   CNT_ONE  = 1;

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ALU_W-1:0]    alu_q, alu_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                last_q, last_d;
    logic                illegal_q, illegal_d;

    logic                in_ready;
    logic                accept;
    logic [OPCODE_W-1:0] rom_opc;
    logic [STEP_W-1:0]   rom_step;
    logic [ALU_W-1:0]    rom_alu;
    logic [CTRL_W-1:0]   rom_ctrl;
    logic [STEP_W:0]     rom_count;
    logic                rom_legal;
    logic                rom_last;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_EXEC) && last_q && !bus.stall);
    assign accept   = bus.in_valid && in_ready;

    // One ROM port serves both a fresh accept (step 0) and the advance to step+1.
    assign rom_opc  = accept ? bus.opcode : opcode_q;
    assign rom_step = accept ? '0 : step_q + STEP_ONE;
    assign rom_last = (({1'b0, rom_step} + CNT_ONE) == rom_count);

    micro_rom #(
        .OPCODE_W (OPCODE_W),
        .ALU_W    (ALU_W),
        .CTRL_W   (CTRL_W),
        .MAX_STEPS(MAX_STEPS),
        .STEP_W   (STEP_W)
    ) u_rom (
        .opcode_i(rom_opc),
        .step_i  (rom_step),
        .alu_o   (rom_alu),
        .ctrl_o  (rom_ctrl),
        .count_o (rom_count),
        .legal_o (rom_legal)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        step_d    = step_q;
        alu_d     = alu_q;
        ctrl_d    = ctrl_q;
        last_d    = last_q;
        illegal_d = 1'b0;
        if (accept || (state_q == S_EXEC && !bus.stall && !last_q)) begin
            state_d   = S_EXEC;
            opcode_d  = rom_opc;
            step_d    = rom_step;
            alu_d     = rom_alu;
            ctrl_d    = rom_ctrl;
            last_d    = rom_last;
            illegal_d = !rom_legal && (rom_step == '0);
        end else if (state_q == S_EXEC && !bus.stall) begin
            state_d  = S_IDLE;
            opcode_d = '0;
            step_d   = '0;
            alu_d    = '0;
            ctrl_d   = '0;
            last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            step_q    <= '0;
            alu_q     <= '0;
            ctrl_q    <= '0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            step_q    <= step_d;
            alu_q     <= alu_d;
            ctrl_q    <= ctrl_d;
            last_q    <= last_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == S_EXEC);
    assign bus.alu_flags  = alu_q;
    assign bus.ctrl_flags = ctrl_q;
    assign bus.step       = step_q;
    assign bus.last       = last_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Parametrised, registered successor to the combinational opcode decoder. It accepts an opcode through a valid/ready handshake and replays a per-opcode sequence of 1..MAX_STEPS micro-steps. Each step drives one alu_flags/ctrl_flags word. This lets multi-phase instructions (jump-and-link, loads) be split across cycles. It sits between instruction fetch and the datapath control inputs, honouring a datapath stall.

Parameters:
OPCODE_W, 4, opcode width; table has 2**OPCODE_W entries
ALU_W, 8, alu_flags width (bit order ci nb ic na xo no rot -)
CTRL_W, 8, ctrl_flags width
MAX_STEPS, 4, maximum micro-steps per opcode (>=2)
STEP_W, $clog2(MAX_STEPS), step index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  opcode offered
in_ready  out  1  sequencer can accept an opcode this cycle
opcode  in  OPCODE_W  opcode, sampled on in_valid&&in_ready
stall  in  1  datapath stall; holds current step
out_valid  out  1  alu_flags/ctrl_flags are a live step
alu_flags  out  ALU_W  registered ALU control for current step
ctrl_flags  out  CTRL_W  registered datapath control for current step
step  out  STEP_W  index of current step
last  out  1  current step is the final step of the opcode
illegal  out  1  one-cycle pulse with step 0 of an undefined opcode

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0, alu_flags=0, ctrl_flags=0, step=0, last=0, illegal=0. Reset mid-sequence aborts the sequence; nothing resumes after release.
- States: IDLE, EXEC.
- in_ready = (IDLE) || (EXEC && last && !stall). Combinational from state, last and stall.
- Accept: in_valid&&in_ready at edge N. Step 0 of the opcode is visible from N+1 (latency 1) and the state becomes EXEC.
- EXEC, stall=1: all outputs held; step does not advance; in_ready=0.
- EXEC, stall=0, !last: step+1 and the next table word load at the next edge.
- EXEC, stall=0, last, new accept: step 0 of the new opcode loads next cycle. Back-to-back operation has no bubble.
- EXEC, stall=0, last, no accept: go to IDLE; outputs zero; out_valid=0.
- In IDLE, outputs are all zero (no stale flags).
- Table (step count; steps as alu/ctrl hex):
  - 0 add: 1; 00/00
  - 1 sub: 1; C0/00
  - 2 xor: 1; 20/00
  - 3 nor: 1; 2C/00
  - 4 and: 1; 7C/00
  - 5 rot: 1; 02/00
  - 7 jlr: 2; 00/10, 00/08
  - 8 jli: 2; 00/20, 00/08
  - 9 b--: 1; 00/A0
  - C adi: 1; 00/40
  - D stb: 1; 00/04
  - E ldb: 2; 00/00, 00/02
  - F ldi: 1; 00/01
- Undefined opcodes (6, A, B and any entry beyond the table when OPCODE_W>4): 1 step, all-zero flags, illegal=1 for that step's first cycle only. illegal is not reasserted while stalled.
- last=1 when step == count-1. The step counter never exceeds MAX_STEPS-1. Counts above MAX_STEPS are clamped at elaboration.
- opcode is ignored when not accepted.

Decomposition:
- Package micro_seq_pkg:
  - ALU_* and CTRL_* constant words listed above.
  - Opcode enum (OP_ADD..OP_LDI).
  - step_t struct {alu, ctrl}.
  - step-count function.
  - Table lookup function (opcode, step) -> step_t.
- Sub-module micro_rom: combinational (opcode, step) -> {alu, ctrl, count, legal}. The sequencer registers its output. The FSM/counter stays in micro_sequencer.

Test Plan:
- Reset: assert rst mid-jlr at step 1 -> outputs 0, out_valid=0, in_ready=1 immediately, asynchronously without a clock edge.
- Single-step: offer sub (1) at edge N -> N+1: alu=C0, ctrl=00, last=1, out_valid=1; N+2 with no new input -> IDLE, all zero.
- Multi-step with stall: accept jli (8), stall=1 for 3 cycles at step 0 -> ctrl=20 held, in_ready=0. After release: ctrl=08, last=1, then idle.
- Back-to-back: in_valid held with ldb (E) then ldi (F) -> ctrl sequence 00, 02, 01 on consecutive cycles; in_ready high on ldb's step 1.
- Illegal: accept opcode A with stall=1 for 2 cycles -> illegal high for exactly 1 cycle, flags 00/00, last=1.
- Sweep: all 16 opcodes, no stall -> per-step words and counts match the table. Total cycles = sum of counts = 19.
